// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if: stall requests, exception redirect and status between pipeline and stall controller
interface pipeline_stall_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int PERF_WIDTH = 32
);
    logic                  stall_req_if;
    logic                  stall_req_id;
    logic                  stall_req_ex;
    logic                  stall_req_mem;
    logic                  exc_req;
    logic [ADDR_WIDTH-1:0] exc_pc_in;
    logic                  timeout_clr;
    logic                  perf_clr;
    logic [4:0]            stall;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] flush_pc;
    logic                  stall_timeout;
    logic [PERF_WIDTH-1:0] stall_cycles;

    modport master (
        output stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
               exc_req, exc_pc_in, timeout_clr, perf_clr,
        input  stall, flush, flush_pc, stall_timeout, stall_cycles
    );

    modport slave (
        input  stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
               exc_req, exc_pc_in, timeout_clr, perf_clr,
        output stall, flush, flush_pc, stall_timeout, stall_cycles
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall vector encoding, memory-safe flush sequencing, stall watchdog and stall-cycle counter
module pipeline_stall_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 1024,
    parameter int PERF_WIDTH = 32
) (
    input logic                clk,
    input logic                rst,
    pipeline_stall_ctrl_if.slave bus
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, PENDING, FLUSH} state_t;

    state_t                state, state_nx;
    logic [4:0]            stall_enc;
    logic [4:0]            stall;
    logic                  latch;
    logic [ADDR_WIDTH-1:0] flush_pc;
    logic [WW-1:0]         wd_cnt;
    logic                  stall_timeout;
    logic [PERF_WIDTH-1:0] stall_cycles;

    always_comb begin
        stall_enc = bus.stall_req_mem ? 5'b01111 :
                    bus.stall_req_ex  ? 5'b00111 :
                    bus.stall_req_id  ? 5'b00011 :
                    bus.stall_req_if  ? 5'b00001 : 5'b00000;
        stall     = (rst || state == FLUSH) ? 5'b00000 : stall_enc;
        latch     = state == IDLE && bus.exc_req;
        state_nx  = state == IDLE    ? (bus.exc_req ? (bus.stall_req_mem ? PENDING : FLUSH) : IDLE) :
                    state == PENDING ? (bus.stall_req_mem ? PENDING : FLUSH) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            flush_pc      <= '0;
            wd_cnt        <= '0;
            stall_timeout <= 1'b0;
            stall_cycles  <= '0;
        end else begin
            state <= state_nx;
            if (latch)
                flush_pc <= bus.exc_pc_in;
            wd_cnt <= (stall == 5'b0) ? '0 : (wd_cnt == WW'(TIMEOUT)) ? wd_cnt : wd_cnt + 1'b1;
            // the edge that brings the count to TIMEOUT raises the flag; set beats clear
            if (stall != 5'b0 && wd_cnt >= WW'(TIMEOUT - 1))
                stall_timeout <= 1'b1;
            else if (bus.timeout_clr)
                stall_timeout <= 1'b0;
            stall_cycles <= bus.perf_clr ? '0 :
                            (stall[0] && !(&stall_cycles)) ? stall_cycles + 1'b1 : stall_cycles;
        end
    end

    assign bus.stall         = stall;
    assign bus.flush         = state == FLUSH;
    assign bus.flush_pc      = flush_pc;
    assign bus.stall_timeout = stall_timeout;
    assign bus.stall_cycles  = stall_cycles;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed checks of stall encoding, flush sequencing, watchdog and counter saturation
module tb_pipeline_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    pipeline_stall_ctrl_if #(.ADDR_WIDTH(32), .PERF_WIDTH(4)) bus ();

    pipeline_stall_ctrl #(.ADDR_WIDTH(32), .TIMEOUT(8), .PERF_WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.stall_req_if  = 0;
        bus.stall_req_id  = 0;
        bus.stall_req_ex  = 0;
        bus.stall_req_mem = 0;
        bus.exc_req       = 0;
        bus.exc_pc_in     = 0;
        bus.timeout_clr   = 0;
        bus.perf_clr      = 0;
        tick();
        tick();
        bus.stall_req_mem = 1;
        #1 chk("rst_stall", 32'(bus.stall), 0);
        bus.stall_req_mem = 0;
        chk("rst_flush", 32'(bus.flush), 0);
        chk("rst_flush_pc", bus.flush_pc, 0);
        chk("rst_timeout", 32'(bus.stall_timeout), 0);
        chk("rst_cycles", 32'(bus.stall_cycles), 0);
        rst = 0;

        for (int i = 0; i < 3; i++) begin
            bus.stall_req_id = 1;
            #1 chk("id_stall", 32'(bus.stall), 32'h03);
            tick();
        end
        bus.stall_req_id = 0;
        #1 chk("id_release", 32'(bus.stall), 0);
        chk("id_cycles", 32'(bus.stall_cycles), 3);
        chk("id_flush", 32'(bus.flush), 0);

        bus.stall_req_if  = 1;
        bus.stall_req_mem = 1;
        #1 chk("mem_wins", 32'(bus.stall), 32'h0F);
        bus.stall_req_mem = 0;
        #1 chk("if_only", 32'(bus.stall), 32'h01);
        bus.stall_req_if = 0;
        bus.stall_req_ex = 1;
        #1 chk("ex_only", 32'(bus.stall), 32'h07);
        bus.stall_req_ex = 0;

        bus.exc_req   = 1;
        bus.exc_pc_in = 32'h1000;
        tick();
        bus.exc_req      = 0;
        bus.stall_req_ex = 1;
        #1 chk("exc_flush", 32'(bus.flush), 1);
        chk("exc_flush_pc", bus.flush_pc, 32'h1000);
        chk("flush_stall_zero", 32'(bus.stall), 0);
        tick();
        chk("exc_flush_end", 32'(bus.flush), 0);
        chk("post_flush_stall", 32'(bus.stall), 32'h07);
        chk("flush_not_counted", 32'(bus.stall_cycles), 3);
        bus.stall_req_ex = 0;

        bus.stall_req_mem = 1;
        bus.exc_req       = 1;
        bus.exc_pc_in     = 32'h2000;
        tick();
        bus.exc_pc_in = 32'h3000;
        #1 chk("pend_flush0", 32'(bus.flush), 0);
        chk("pend_pc", bus.flush_pc, 32'h2000);
        tick();
        bus.exc_req = 0;
        #1 chk("pend_flush1", 32'(bus.flush), 0);
        chk("pend_stall", 32'(bus.stall), 32'h0F);
        tick();
        chk("pend_flush2", 32'(bus.flush), 0);
        tick();
        bus.stall_req_mem = 0;
        #1 chk("pend_flush3", 32'(bus.flush), 0);
        tick();
        chk("pend_fire", 32'(bus.flush), 1);
        chk("pend_fire_pc", bus.flush_pc, 32'h2000);
        bus.exc_req   = 1;
        bus.exc_pc_in = 32'h5000;
        tick();
        bus.exc_req = 0;
        chk("flush_exc_ignored", 32'(bus.flush), 0);
        chk("flush_pc_kept", bus.flush_pc, 32'h2000);
        chk("pend_cycles", 32'(bus.stall_cycles), 7);

        bus.stall_req_id = 1;
        bus.perf_clr     = 1;
        tick();
        bus.perf_clr     = 0;
        bus.stall_req_id = 0;
        chk("perf_clr_wins", 32'(bus.stall_cycles), 0);
        tick();

        bus.stall_req_ex = 1;
        for (int i = 0; i < 8; i++) begin
            #1 chk("wd_not_yet", 32'(bus.stall_timeout), 0);
            tick();
        end
        chk("wd_trip", 32'(bus.stall_timeout), 1);
        bus.timeout_clr = 1;
        tick();
        bus.timeout_clr = 0;
        chk("wd_set_wins", 32'(bus.stall_timeout), 1);
        bus.stall_req_ex = 0;
        tick();
        chk("wd_sticky", 32'(bus.stall_timeout), 1);
        chk("wd_cycles", 32'(bus.stall_cycles), 9);
        bus.timeout_clr = 1;
        tick();
        bus.timeout_clr = 0;
        chk("wd_cleared", 32'(bus.stall_timeout), 0);

        bus.stall_req_if = 1;
        for (int i = 0; i < 20; i++)
            tick();
        bus.stall_req_if = 0;
        chk("perf_saturate", 32'(bus.stall_cycles), 32'hF);
        chk("wd_retrip", 32'(bus.stall_timeout), 1);

        bus.stall_req_mem = 1;
        bus.exc_req       = 1;
        bus.exc_pc_in     = 32'h4000;
        tick();
        bus.exc_req = 0;
        chk("rst_pend_pc", bus.flush_pc, 32'h4000);
        rst = 1;
        tick();
        rst = 0;
        bus.stall_req_mem = 0;
        chk("rst_pend_flush", 32'(bus.flush), 0);
        chk("rst_pend_flush_pc", bus.flush_pc, 0);
        chk("rst_pend_cycles", 32'(bus.stall_cycles), 0);
        chk("rst_pend_timeout", 32'(bus.stall_timeout), 0);
        tick();
        chk("rst_pend_no_flush", 32'(bus.flush), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush controller for the five-stage pipeline. It turns per-stage stall requests into the stall vector that drives every pipeline register's stall_current_stage/stall_next_stage pair. It sequences exception/redirect flushes so a flush never fires while a memory access is in flight. It also keeps a stall watchdog and a saturating stall-cycle performance counter.

Parameters:
ADDR_WIDTH, 32, width of PC / flush target address
TIMEOUT, 1024, consecutive stalled cycles before the watchdog trips (>=2)
PERF_WIDTH, 32, width of the stall-cycle counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
stall_req_if  input  1  fetch stall (icache miss)
stall_req_id  input  1  decode stall (load-use hazard)
stall_req_ex  input  1  execute stall (multi-cycle mul/div)
stall_req_mem  input  1  memory stall (dcache/bus busy)
exc_req  input  1  exception/redirect request, single-cycle pulse
exc_pc_in  input  ADDR_WIDTH  redirect target, valid with exc_req
timeout_clr  input  1  clears the stall_timeout flag
perf_clr  input  1  clears stall_cycles
stall  output  5  [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB
flush  output  1  flush all pipeline registers, registered
flush_pc  output  ADDR_WIDTH  PC redirect target, valid while flush=1
stall_timeout  output  1  sticky watchdog flag
stall_cycles  output  PERF_WIDTH  saturating count of cycles with stall[0]=1

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high. One clock domain.
- Reset values: state=IDLE, flush=0, flush_pc=0, stall_timeout=0, stall_cycles=0, watchdog count=0. stall=0 while rst=1.
- Stall vector is combinational, with zero latency from the requests:
  - stall_req_mem -> 5'b01111
  - else stall_req_ex -> 5'b00111
  - else stall_req_id -> 5'b00011
  - else stall_req_if -> 5'b00001
  - else 0
- The highest requesting stage wins. Stage k stalls bits 0..k-1 plus the PC. The register just downstream of the stalled stage sees current=1, next=0 and inserts a bubble.
- FSM has three states: IDLE, PENDING, FLUSH.
  - IDLE, exc_req=1, stall_req_mem=0 -> FLUSH. Latch exc_pc_in into flush_pc.
  - IDLE, exc_req=1, stall_req_mem=1 -> PENDING. Latch exc_pc_in.
  - PENDING: stay while stall_req_mem=1. -> FLUSH on the first cycle stall_req_mem=0.
  - FLUSH: lasts exactly one cycle, flush=1. -> IDLE unconditionally.
- flush is registered: flush=1 exactly in the cycle the FSM is in FLUSH. flush_pc holds its value until the next accepted exc_req.
- In FLUSH, stall is forced to 0 regardless of requests, so every register loads its reset value.
- In PENDING, stall follows the normal encoding.
- exc_req while in PENDING or FLUSH is ignored (first exception wins) and flush_pc is not overwritten. The upstream exception unit must re-raise it.
- Watchdog counter:
  - Increments each cycle with stall!=0; resets to 0 on any cycle with stall=0.
  - Saturates at TIMEOUT.
  - When it reaches TIMEOUT (TIMEOUT consecutive stalled cycles), stall_timeout is set the next cycle.
- stall_timeout is cleared by timeout_clr. If clear and set conditions coincide, set wins.
- stall_cycles increments on each cycle with stall[0]=1 and saturates at all-ones (no wrap). perf_clr clears it to 0; perf_clr wins over increment in the same cycle.
- Reset asserted mid-PENDING or mid-FLUSH: the next state is IDLE, flush=0, and the latched pc is discarded (flush_pc=0).

Test Plan:
- Reset, then stall_req_id=1 for 3 cycles -> stall=5'b00011 in those 3 cycles; stall_cycles=3; flush=0.
- stall_req_if=1 and stall_req_mem=1 together -> stall=5'b01111. Drop mem, keep if -> stall=5'b00001 in the same cycle.
- exc_req=1, exc_pc_in=32'h0000_1000, no stalls -> next cycle flush=1, flush_pc=32'h1000, stall=0 even if stall_req_ex=1. The cycle after, flush=0.
- stall_req_mem=1 for 4 cycles, exc_req pulse with pc 32'h2000 in cycle 1, second exc_req with 32'h3000 in cycle 2 -> flush=0 while mem is stalled. flush=1 with flush_pc=32'h2000 in the cycle after stall_req_mem falls.
- TIMEOUT=8, stall_req_ex held 8 cycles -> stall_timeout=1 on the following cycle. timeout_clr pulsed while the stall persists -> flag stays 1. Remove the stall, then timeout_clr -> flag 0.
- rst asserted while in PENDING (pc 32'h4000) -> flush stays 0, flush_pc=0, stall_cycles=0. Also force stall_cycles to all-ones with PERF_WIDTH=4 and 20 stalled cycles -> holds 4'hF.
